// File: rtl/comma_aligner.sv
// Serial-to-parallel 8b/10b comma aligner: hunts K28.5, verifies, locks, and emits aligned 10-bit words.
// Latency 1 cycle from last bit of a word to VALID; no backpressure, one word per 10 bits when aligned.
module comma_aligner #(
  parameter int COMMA_LOCK     = 3,
  parameter int ERR_LIMIT      = 3,
  parameter int VERIFY_TIMEOUT = 32
) (
  input  logic       CLK,
  input  logic       RESET_ALN,
  input  logic       IN_SERIAL,
  output logic [9:0] OUT_PARALELO,
  output logic       VALID,
  output logic       K_COMMA,
  output logic       SYNC
);

  localparam int CW = (COMMA_LOCK < 1) ? 1 : $clog2(COMMA_LOCK + 1);
  localparam int WW = (VERIFY_TIMEOUT < 1) ? 1 : $clog2(VERIFY_TIMEOUT + 1);
  localparam int EW = (ERR_LIMIT < 1) ? 1 : $clog2(ERR_LIMIT + 1);
  localparam logic [CW-1:0] C_LOCK = CW'(COMMA_LOCK);
  localparam logic [WW-1:0] W_TO   = WW'(VERIFY_TIMEOUT);
  localparam logic [EW-1:0] E_LIM  = EW'(ERR_LIMIT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        r_state;
  logic [9:0]    r_sr;
  logic [3:0]    r_bitcnt;
  logic [CW-1:0] r_ccnt;
  logic [WW-1:0] r_wcnt;
  logic [EW-1:0] r_errcnt;

  logic          w_cm;
  logic          w_aligned;
  logic          w_bnd;
  logic          w_emit;
  logic [CW-1:0] w_ccnt_inc;
  logic [WW-1:0] w_wcnt_inc;
  logic [EW-1:0] w_err_inc;

  assign w_cm      = (r_sr == 10'b0011111010) || (r_sr == 10'b1100000101);
  assign w_aligned = (r_bitcnt == 4'd9);
  assign w_bnd     = w_aligned || ((r_state == HUNT) && w_cm);
  // In HUNT only a comma produces a word; elsewhere every grid boundary does.
  assign w_emit    = (r_state == HUNT) ? w_cm : w_aligned;

  assign w_ccnt_inc = (r_ccnt >= C_LOCK) ? r_ccnt : r_ccnt + CW'(1);
  assign w_wcnt_inc = (r_wcnt >= W_TO) ? r_wcnt : r_wcnt + WW'(1);
  assign w_err_inc  = (r_errcnt >= E_LIM) ? r_errcnt : r_errcnt + EW'(1);

  always_ff @(posedge CLK or negedge RESET_ALN) begin
    if (!RESET_ALN) begin
      r_state      <= HUNT;
      r_sr         <= '0;
      r_bitcnt     <= '0;
      r_ccnt       <= '0;
      r_wcnt       <= '0;
      r_errcnt     <= '0;
      OUT_PARALELO <= '0;
      VALID        <= 1'b0;
      K_COMMA      <= 1'b0;
      SYNC         <= 1'b0;
    end else begin
      r_sr     <= {r_sr[8:0], IN_SERIAL};
      r_bitcnt <= w_bnd ? 4'd0 : r_bitcnt + 4'd1;
      VALID    <= w_emit;
      K_COMMA  <= w_emit && w_cm;
      if (w_emit) begin
        OUT_PARALELO <= r_sr;
      end

      case (r_state)
        HUNT: begin
          if (w_cm) begin
            r_state <= VERIFY;
            r_ccnt  <= CW'(1);
            r_wcnt  <= '0;
          end
        end
        VERIFY: begin
          if (w_cm && !w_aligned) begin
            r_state <= HUNT;
          end else if (w_aligned) begin
            r_wcnt <= w_wcnt_inc;
            if (w_cm) begin
              r_ccnt <= w_ccnt_inc;
            end
            // Lock takes priority over a timeout landing on the same word.
            if (w_cm && (w_ccnt_inc >= C_LOCK)) begin
              r_state  <= LOCKED;
              r_errcnt <= '0;
              SYNC     <= 1'b1;
            end else if (w_wcnt_inc >= W_TO) begin
              r_state <= HUNT;
            end
          end
        end
        LOCKED: begin
          if (w_cm) begin
            if (w_aligned) begin
              r_errcnt <= '0;
            end else if (w_err_inc >= E_LIM) begin
              r_state  <= HUNT;
              r_errcnt <= '0;
              SYNC     <= 1'b0;
            end else begin
              r_errcnt <= w_err_inc;
            end
          end
        end
        default: begin
          r_state <= HUNT;
          SYNC    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: directed scenarios plus random word streams, each checked cycle by cycle
// against a bit-position reference model of the hunt/verify/lock rules.
module tb_comma_aligner;

  localparam int COMMA_LOCK     = 3;
  localparam int ERR_LIMIT      = 3;
  localparam int VERIFY_TIMEOUT = 32;
  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] K_POS = 10'b1100000101;
  localparam logic [9:0] D215  = 10'b1010101010;

  logic       CLK = 1'b0;
  logic       RESET_ALN = 1'b0;
  logic       IN_SERIAL = 1'b0;
  logic [9:0] OUT_PARALELO;
  logic       VALID;
  logic       K_COMMA;
  logic       SYNC;

  int checks = 0;
  int failures = 0;

  // Observation/expectation vector per cycle: {VALID, K_COMMA, SYNC, OUT_PARALELO}
  bit          stim[$];
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];

  always #5 CLK = ~CLK;

  comma_aligner #(
    .COMMA_LOCK    (COMMA_LOCK),
    .ERR_LIMIT     (ERR_LIMIT),
    .VERIFY_TIMEOUT(VERIFY_TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .RESET_ALN   (RESET_ALN),
    .IN_SERIAL   (IN_SERIAL),
    .OUT_PARALELO(OUT_PARALELO),
    .VALID       (VALID),
    .K_COMMA     (K_COMMA),
    .SYNC        (SYNC)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic void add_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) stim.push_back(w[i]);
  endfunction

  // The 10 most recent bits ending at stream position n, oldest bit in the MSB.
  function automatic logic [9:0] win_at(input int n);
    logic [9:0] w = '0;
    for (int j = 0; j < 10; j++) begin
      if (n - 9 + j >= 0) w[9-j] = stim[n-9+j];
    end
    return w;
  endfunction

  // Walks the stream bit position by bit position; the word grid is kept as the
  // absolute position where the next aligned word ends.
  function automatic void build_model();
    int mode = 0;
    int next_end = 0;
    int ccount = 0;
    int wcount = 0;
    int errs = 0;
    logic [9:0] held = '0;
    exp_q.delete();
    for (int n = 0; n < stim.size(); n++) begin
      logic [9:0] w;
      bit comma, on_grid, emit;
      w = win_at(n);
      comma = (w == K_NEG) || (w == K_POS);
      on_grid = (mode != 0) && (n == next_end);
      emit = 1'b0;
      if (mode == 0) begin
        if (comma) begin
          emit = 1'b1; mode = 1; ccount = 1; wcount = 0; next_end = n + 10;
        end
      end else if (mode == 1) begin
        if (comma && !on_grid) mode = 0;
        else if (on_grid) begin
          emit = 1'b1; next_end += 10; wcount++;
          if (comma) ccount++;
          if (comma && ccount >= COMMA_LOCK) begin mode = 2; errs = 0; end
          else if (wcount >= VERIFY_TIMEOUT) mode = 0;
        end
      end else begin
        if (on_grid) begin
          emit = 1'b1; next_end += 10;
          if (comma) errs = 0;
        end else if (comma) begin
          errs++;
          if (errs >= ERR_LIMIT) mode = 0;
        end
      end
      if (emit) held = w;
      exp_q.push_back({emit, emit && comma, mode == 2, held});
    end
  endfunction

  function automatic int count_pos(input int pos, input int from, input int upto);
    int c = 0;
    for (int k = from; k < upto && k < obs_q.size(); k++) if (obs_q[k][pos]) c++;
    return c;
  endfunction

  function automatic int sync_rises();
    int c = 0;
    logic prev = 1'b0;
    for (int k = 0; k < obs_q.size(); k++) begin
      if (obs_q[k][10] && !prev) c++;
      prev = obs_q[k][10];
    end
    return c;
  endfunction

  task automatic apply_reset();
    RESET_ALN = 1'b0;
    IN_SERIAL = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_ALN = 1'b1;
    stim.delete();
  endtask

  // Drives stim and records outputs #1 after each edge; obs_q[k] reflects window k.
  task automatic run_stream();
    build_model();
    obs_q.delete();
    for (int n = 0; n <= stim.size(); n++) begin
      IN_SERIAL = (n < stim.size()) ? stim[n] : 1'b0;
      @(posedge CLK);
      #1;
      if (n >= 1) obs_q.push_back({VALID, K_COMMA, SYNC, OUT_PARALELO});
    end
  endtask

  task automatic test_reset();
    RESET_ALN = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if ({VALID, K_COMMA, SYNC, OUT_PARALELO} !== 13'd0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", {VALID, K_COMMA, SYNC, OUT_PARALELO}, 13'd0);
    end
  endtask

  task automatic test_no_comma();
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      logic [9:0] w;
      stim.push_back(1'($urandom_range(0, 1)));
      w = win_at(stim.size() - 1);
      if (w == K_NEG || w == K_POS) stim[stim.size()-1] = ~stim[stim.size()-1];
    end
    run_stream();
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL no_comma cyc=%0d got=%b exp=%b", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (count_pos(12, 0, obs_q.size()) != 0 || count_pos(10, 0, obs_q.size()) != 0) begin
      failures++;
      $display("FAIL no_comma_outputs valid=%0d sync=%0d exp 0/0",
               count_pos(12, 0, obs_q.size()), count_pos(10, 0, obs_q.size()));
    end
  endtask

  task automatic test_basic_align();
    logic [9:0] ew[4] = '{K_NEG, K_POS, D215, K_NEG};
    bit ek[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
    add_word(K_NEG); add_word(K_POS); add_word(D215); add_word(K_NEG);
    run_stream();
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%b exp=%b", k, obs_q[k], exp_q[k]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      int idx = 12 + 10 * i;
      checks++;
      if (obs_q[idx] !== {1'b1, ek[i], (i == 3), ew[i]}) begin
        failures++;
        $display("FAIL basic_word%0d got=%b exp=%b", i, obs_q[idx], {1'b1, ek[i], (i == 3), ew[i]});
      end
    end
    checks++;
    if (count_pos(12, 0, obs_q.size()) != 4 || obs_q[41][10] !== 1'b0) begin
      failures++;
      $display("FAIL basic_count valid=%0d sync_before=%b exp 4/0",
               count_pos(12, 0, obs_q.size()), obs_q[41][10]);
    end
  endtask

  task automatic test_slip_relock();
    int late_end;
    apply_reset();
    add_word(K_NEG); add_word(K_POS); add_word(K_NEG); add_word(D215);
    stim.push_back(1'b0);
    add_word(K_NEG); add_word(K_POS); add_word(K_NEG);
    late_end = stim.size() - 1;
    add_word(K_NEG); add_word(K_POS); add_word(K_NEG); add_word(D215);
    run_stream();
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL slip cyc=%0d got=%b exp=%b", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (obs_q[late_end-1][10] !== 1'b1 || obs_q[late_end][10] !== 1'b0) begin
      failures++;
      $display("FAIL slip_drop sync_before=%b sync_after=%b exp 1/0",
               obs_q[late_end-1][10], obs_q[late_end][10]);
    end
    checks++;
    if (count_pos(11, 0, obs_q.size()) != 6 || sync_rises() != 2 || obs_q[obs_q.size()-1][10] !== 1'b1) begin
      failures++;
      $display("FAIL slip_relock kcount=%0d rises=%0d final_sync=%b exp 6/2/1",
               count_pos(11, 0, obs_q.size()), sync_rises(), obs_q[obs_q.size()-1][10]);
    end
  endtask

  task automatic test_verify_timeout();
    apply_reset();
    add_word(K_NEG);
    for (int i = 0; i < 35; i++) add_word(D215);
    run_stream();
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%b exp=%b", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (count_pos(12, 0, obs_q.size()) != 33 || count_pos(11, 0, obs_q.size()) != 1 ||
        count_pos(10, 0, obs_q.size()) != 0 || obs_q[329][12] !== 1'b1 || obs_q[339][12] !== 1'b0) begin
      failures++;
      $display("FAIL timeout_counts valid=%0d k=%0d sync=%0d last=%b after=%b exp 33/1/0/1/0",
               count_pos(12, 0, obs_q.size()), count_pos(11, 0, obs_q.size()),
               count_pos(10, 0, obs_q.size()), obs_q[329][12], obs_q[339][12]);
    end
  endtask

  task automatic test_misaligned_verify();
    int mis_end;
    apply_reset();
    add_word(K_NEG);
    stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b0);
    add_word(K_NEG);
    mis_end = stim.size() - 1;
    add_word(D215); add_word(D215); add_word(D215);
    run_stream();
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL misalign cyc=%0d got=%b exp=%b", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (count_pos(12, 0, obs_q.size()) != 2 || count_pos(11, 0, obs_q.size()) != 1 ||
        count_pos(12, mis_end, obs_q.size()) != 0) begin
      failures++;
      $display("FAIL misalign_counts valid=%0d k=%0d valid_after=%0d exp 2/1/0",
               count_pos(12, 0, obs_q.size()), count_pos(11, 0, obs_q.size()),
               count_pos(12, mis_end, obs_q.size()));
    end
  endtask

  task automatic test_reset_async();
    apply_reset();
    add_word(K_NEG); add_word(K_POS); add_word(K_NEG); add_word(D215);
    for (int i = 0; i < 5; i++) stim.push_back(K_NEG[9-i]);
    run_stream();
    checks++;
    if (SYNC !== 1'b1) begin
      failures++;
      $display("FAIL async_pre_lock sync=%b exp=1", SYNC);
    end
    #3;
    RESET_ALN = 1'b0;
    #1;
    checks++;
    if ({VALID, K_COMMA, SYNC, OUT_PARALELO} !== 13'd0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", {VALID, K_COMMA, SYNC, OUT_PARALELO}, 13'd0);
    end
    apply_reset();
    for (int i = 5; i < 10; i++) stim.push_back(K_NEG[9-i]);
    add_word(D215); add_word(K_NEG); add_word(K_POS); add_word(K_NEG);
    run_stream();
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL async_resume cyc=%0d got=%b exp=%b", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (count_pos(12, 0, 24) != 0 || obs_q[24][12:11] !== 2'b11 || obs_q[44][10] !== 1'b1) begin
      failures++;
      $display("FAIL async_fresh early=%0d first=%b sync=%b exp 0/11/1",
               count_pos(12, 0, 24), obs_q[24][12:11], obs_q[44][10]);
    end
  endtask

  task automatic test_random_traffic();
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      for (int w = 0; w < 40; w++) begin
        int r = $urandom_range(0, 9);
        logic [9:0] rw = 10'($urandom_range(0, 1023));
        if (r <= 3) add_word((w % 2) ? K_POS : K_NEG);
        else if (r <= 6) add_word(D215);
        else if (r <= 8) add_word(rw);
        else begin
          int nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) stim.push_back(1'($urandom_range(0, 1)));
          add_word(K_NEG);
        end
      end
      run_stream();
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_comma();
    test_basic_align();
    test_slip_relock();
    test_verify_timeout();
    test_misaligned_verify();
    test_reset_async();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
